apb_regfile_slave: RTL and testbench
====================================

Name: apb_regfile_slave

Overview:
- Parametrised APB4 slave register file. Successor to the fixed 8-bit-address / 32-bit-data APB link.
- Adds generic address/data width, register count, configurable wait states, byte strobes and error response.
- Some registers are software read/write (RW) control registers. The rest are read-only (RO) status registers fed by hardware.
- Sits behind the APB master on the peripheral bus.

Parameters:
- ADDR_WIDTH, 8, PADDR width in bits.
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32.
- NUM_REGS, 16, number of word registers; must be ≤ 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_STATES, 0, PREADY-low cycles inserted in every access phase; range 0..15.
- RO_MASK, 0, NUM_REGS-bit mask; bit i = 1 makes register i read-only.

Ports:
- PCLK, in, 1, bus clock.
- PRESETn, in, 1, asynchronous active-low reset.
- PSEL, in, 1, slave select.
- PENABLE, in, 1, access-phase indicator.
- PWRITE, in, 1, 1 = write, 0 = read.
- PADDR, in, ADDR_WIDTH, byte address.
- PWDATA, in, DATA_WIDTH, write data.
- PSTRB, in, DATA_WIDTH/8, byte-lane write enables.
- PRDATA, out, DATA_WIDTH, read data.
- PREADY, out, 1, transfer completion.
- PSLVERR, out, 1, transfer error; valid only with PREADY.
- regs_o, out, NUM_REGS*DATA_WIDTH, flattened RW register contents; register i is at slice [i*DATA_WIDTH +: DATA_WIDTH].
- status_i, in, NUM_REGS*DATA_WIDTH, hardware values returned on reads of RO registers.

Behaviour:
- Interface: single clock PCLK; reset PRESETn is asynchronous, active-low.
- Reset values: all RW registers 0, FSM in IDLE, wait counter 0. PREADY, PSLVERR and PRDATA are all 0. RO slices of regs_o are always 0.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when PSEL=1, PENABLE=0.
  - SETUP -> ACCESS unconditionally on the next edge.
  - ACCESS stays in ACCESS while PREADY=0.
  - On the edge where PREADY=1 (completion): -> SETUP if PSEL=1 and PENABLE=0 (back-to-back); otherwise -> IDLE.
  - PSEL=1 with PENABLE=1 seen in IDLE is a protocol violation: ignored, PREADY held 0, no register change.
- Wait counter:
  - Cleared in SETUP; increments each ACCESS cycle while PREADY=0.
  - PREADY = 1 exactly when state = ACCESS and counter == WAIT_STATES, combinational from state and counter.
  - Access phase lasts WAIT_STATES+1 cycles. WAIT_STATES=0 gives zero-wait transfers.
- Decode:
  - index = PADDR >> log2(DATA_WIDTH/8).
  - Error if any low byte-offset bit is nonzero (unaligned) or if index ≥ NUM_REGS.
  - Error if the access is a write to an RO register.
  - Reads of RO registers are not errors.
- PSLVERR = error & PREADY. It is 0 whenever PREADY = 0.
- Write commit:
  - Happens on the PCLK edge ending the PREADY=1 cycle, only if PWRITE=1 and there is no error.
  - Byte lane b is updated only if PSTRB[b]=1. PSTRB=0 is a legal no-op write with no error.
- Read data:
  - In the PREADY=1 cycle of a read: PRDATA = RW register value, or status_i slice for an RO register.
  - PRDATA = 0 on error, on writes, and in all other cycles.
  - status_i is sampled combinationally in the completion cycle.
- Write-then-read: a write followed immediately by a read of the same register returns the new value; a register never reads stale data.
- Mid-transfer events:
  - PSEL dropping mid-access aborts the transfer: -> IDLE, no commit.
  - PRESETn low at any time immediately forces the reset values. An in-flight write is lost.
- Registers are updated only via APB. There is no hardware write path to RW registers.

Test Plan:
1. WAIT_STATES=0: write 0xDEADBEEF to addr 0x04 with PSTRB=0xF, then read 0x04 -> PREADY high in the first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0, regs_o slice 1 = 0xDEADBEEF.
2. Byte strobes: reg 2 = 0x11223344; write 0xAABBCCDD to addr 0x08 with PSTRB=0b0101 -> read returns 0x11BB33DD.
3. WAIT_STATES=3: single read -> PREADY low for 3 access cycles and high on the 4th. Back-to-back write then read -> no idle cycle required; both complete correctly.
4. Errors:
   - Read of addr 0x40 (index 16 with NUM_REGS=16) -> PSLVERR=1, PRDATA=0.
   - Write to unaligned addr 0x05 -> PSLVERR=1, no register changes.
   - Write to an RO register (RO_MASK bit 3, addr 0x0C) -> PSLVERR=1.
   - Read of addr 0x0C with status_i slice 3 = 0xCAFE0001 -> PRDATA=0xCAFE0001, PSLVERR=0.
5. Reset mid-write: assert PRESETn=0 during the ACCESS phase of a write of 0x12345678 -> PREADY=0 immediately, register stays 0 after reset release, and a following read returns 0.
6. Protocol violation: PSEL=1, PENABLE=1 driven from IDLE -> PREADY stays 0 and there is no write. A subsequent proper SETUP/ACCESS completes normally.

Source files
------------

// File: rtl/apb_regfile_slave.sv
//------------------------------------------------------------------------------
// apb_regfile_slave
//
// Parametrised APB4 slave register file. Each word register is either a
// software read/write control register or, when its RO_MASK bit is set, a
// read-only status register whose read value comes straight from status_i.
// Every access phase is stretched by WAIT_STATES cycles. Unaligned or
// out-of-range addresses, and writes to read-only registers, complete with
// PSLVERR.
//
// Ports
//   PCLK, PRESETn      bus clock, asynchronous active-low reset
//   PSEL, PENABLE      APB select and access-phase indicator
//   PWRITE             1 = write, 0 = read
//   PADDR              byte address (ADDR_WIDTH bits)
//   PWDATA, PSTRB      write data and byte-lane enables
//   PRDATA             read data, nonzero only in a good read's ready cycle
//   PREADY, PSLVERR    transfer completion and error (error only with ready)
//   regs_o             flattened RW register contents, RO slices tied to 0
//   status_i           flattened hardware values returned for RO registers
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module apb_regfile_slave #(
    parameter int                  ADDR_WIDTH  = 8,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((1 << OFFS) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // state_q only ever holds IDLE or ACCESS: the setup phase is recognised
    // from the live bus while state_q is IDLE. This gives zero-wait transfers
    // and lets a new setup follow a completion with no idle cycle.
    state_t state_q;
    state_t phase;
    state_t state_d;

    logic [3:0]            wait_cnt;
    logic                  access_done;

    logic [ADDR_WIDTH-1:0] idx;
    logic [IDX_W-1:0]      reg_sel;
    logic                  unaligned;
    logic                  in_range;
    logic                  dec_err;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rd_value;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    //--------------------------------------------------------------------------
    // Address decode
    //--------------------------------------------------------------------------
    assign idx       = PADDR >> OFFS;
    assign reg_sel   = idx[IDX_W-1:0];
    assign unaligned = (PADDR & OFFS_MASK) != '0;
    assign in_range  = (32'(idx) < 32'(NUM_REGS));
    assign dec_err   = unaligned || !in_range || (PWRITE && RO_MASK[reg_sel]);
    assign rd_value  = RO_MASK[reg_sel] ? status_i[reg_sel*DATA_WIDTH +: DATA_WIDTH]
                                        : regs[reg_sel];

    // The access phase ends when the counter has spent WAIT_STATES cycles.
    assign access_done = (state_q == ACCESS) && (wait_cnt == 4'(WAIT_STATES));

    // A dropped PSEL in the ready cycle is an abort, so it never commits.
    assign commit = access_done && PSEL && PWRITE && !dec_err;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // values from before the edge, independent of block ordering.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        phase   = state_q;
        state_d = IDLE;
        // PSEL with PENABLE already high from IDLE is a protocol violation
        // and is left in IDLE.
        if (state_q == IDLE && PSEL && !PENABLE) begin
            phase = SETUP;
        end
        case (phase)
            IDLE:    state_d = IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (PSEL && !access_done) ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------------
    always_comb begin
        PREADY  = access_done;
        PSLVERR = access_done && dec_err;
        PRDATA  = '0;
        if (access_done && !PWRITE && !dec_err) begin
            PRDATA = rd_value;
        end
    end

    //--------------------------------------------------------------------------
    // Wait-state counter
    //--------------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (phase == SETUP) begin
            wait_cnt <= '0;
        end else if (state_q == ACCESS && !access_done) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    //--------------------------------------------------------------------------
    // Register storage with byte-lane writes
    //--------------------------------------------------------------------------
    // NOTE: this array is small control state whose reset value is visible on
    // regs_o, so it is reset with the rest of the logic rather than treated
    // as an uninitialised RAM.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (PSTRB[b]) begin
                    regs[reg_sel][b*8 +: 8] <= PWDATA[b*8 +: 8];
                end
            end
        end
    end

    // RO registers are never written, but their slices are forced to 0 so
    // downstream logic never depends on that.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
//------------------------------------------------------------------------------
// tb_apb_regfile_slave
//
// Two instances share clock and reset: dut 0 has zero wait states, dut 1 has
// three. Both have registers 3 and 7 read-only. A word-level model (one
// array per instance) predicts read data, errors, wait cycles and the
// regs_o contents.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_apb_regfile_slave;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int NR  = 16;
    localparam int SW  = DW / 8;
    localparam int WS0 = 0;
    localparam int WS1 = 3;
    localparam logic [NR-1:0] RO = 16'h0088;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]                psel    = '0;
    logic [1:0]                penable = '0;
    logic [1:0]                pwrite  = '0;
    logic [1:0][AW-1:0]        paddr   = '0;
    logic [1:0][DW-1:0]        pwdata  = '0;
    logic [1:0][SW-1:0]        pstrb   = '0;
    logic [1:0][NR*DW-1:0]     status_i = '0;
    logic [1:0]                pready;
    logic [1:0]                pslverr;
    logic [1:0][DW-1:0]        prdata;
    logic [1:0][NR*DW-1:0]     regs_o;

    apb_regfile_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
        .WAIT_STATES(WS0), .RO_MASK(RO)
    ) dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PSTRB(pstrb[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0]), .regs_o(regs_o[0]), .status_i(status_i[0])
    );

    apb_regfile_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
        .WAIT_STATES(WS1), .RO_MASK(RO)
    ) dut1 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PSTRB(pstrb[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1]), .regs_o(regs_o[1]), .status_i(status_i[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: register words per instance.
    logic [DW-1:0] mem [2][NR];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NR; i++)
                mem[d][i] = '0;
    endfunction

    function automatic logic [NR*DW-1:0] exp_regs(input int d);
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++)
            v[i*DW +: DW] = RO[i] ? '0 : mem[d][i];
        return v;
    endfunction

    task automatic bus_idle(input int d);
        @(negedge clk);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        pwrite[d]  = 1'b0;
        pstrb[d]   = '0;
    endtask

    // One APB transfer; returns at the ready cycle (#1 after its falling edge)
    // with the bus still in the access phase, so a following call is
    // back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [SW-1:0] sb,
                        output logic [DW-1:0] rd, output logic er,
                        output int waits);
        bit got;
        @(negedge clk);
        psel[1-d]    = 1'b0;
        penable[1-d] = 1'b0;
        psel[d]      = 1'b1;
        penable[d]   = 1'b0;
        pwrite[d]    = wr;
        paddr[d]     = a;
        pwdata[d]    = wd;
        pstrb[d]     = sb;
        @(negedge clk);
        penable[d] = 1'b1;
        got   = 1'b0;
        waits = 0;
        rd    = '0;
        er    = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (pready[d] === 1'b1) begin
                rd  = prdata[d];
                er  = pslverr[d];
                got = 1'b1;
            end else begin
                total++;
                if (pslverr[d] !== 1'b0 || prdata[d] !== '0) begin
                    bad++;
                    $display("FAIL wait_outputs dut%0d: pslverr=%b prdata=%h, required 0 and 0",
                             d, pslverr[d], prdata[d]);
                end
                waits++;
                @(negedge clk);
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL pready_timeout dut%0d: no PREADY within 40 cycles", d);
        end
    endtask

    // Transfer checked against the model, then regs_o checked after the edge
    // that ends the ready cycle.
    task automatic do_op(input int d, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [SW-1:0] sb,
                         output logic [DW-1:0] rd);
        int            ai, idx, ws, waits;
        bit            e_err;
        logic [DW-1:0] e_rd;
        logic          er;
        ai    = int'(a);
        idx   = ai / SW;
        ws    = (d == 0) ? WS0 : WS1;
        e_err = (ai % SW) != 0 || idx >= NR;
        if (!e_err && wr && RO[idx]) e_err = 1'b1;
        e_rd = '0;
        if (!wr && !e_err) e_rd = RO[idx] ? status_i[d][idx*DW +: DW] : mem[d][idx];

        xfer(d, wr, a, wd, sb, rd, er, waits);

        total++;
        if (er !== e_err) begin
            bad++;
            $display("FAIL pslverr dut%0d addr=%h wr=%0d: got %b, required %b", d, a, wr, er, e_err);
        end
        total++;
        if (rd !== e_rd) begin
            bad++;
            $display("FAIL prdata dut%0d addr=%h wr=%0d: got %h, required %h", d, a, wr, rd, e_rd);
        end
        total++;
        if (waits != ws) begin
            bad++;
            $display("FAIL wait_cycles dut%0d: got %0d, required %0d", d, waits, ws);
        end
        if (wr && !e_err)
            for (int b = 0; b < SW; b++)
                if (sb[b]) mem[d][idx][b*8 +: 8] = wd[b*8 +: 8];

        @(posedge clk);
        #1;
        total++;
        if (regs_o[d] !== exp_regs(d)) begin
            bad++;
            $display("FAIL regs_o dut%0d after addr=%h: got %h, required %h", d, a, regs_o[d], exp_regs(d));
        end
    endtask

    task automatic expect_word(input string name, input logic [DW-1:0] got,
                               input logic [DW-1:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic test_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== '0 || regs_o[d] !== '0) begin
                bad++;
                $display("FAIL reset_state dut%0d: pready=%b pslverr=%b prdata=%h regs_o=%h, required all 0",
                         d, pready[d], pslverr[d], prdata[d], regs_o[d]);
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if (regs_o[0] !== '0 || regs_o[1] !== '0 || pready !== 2'b00) begin
            bad++;
            $display("FAIL after_reset: regs_o0=%h regs_o1=%h pready=%b, required 0", regs_o[0], regs_o[1], pready);
        end
    endtask

    task automatic test_zero_wait();
        logic [DW-1:0] rd;
        do_op(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd);
        expect_word("zero_wait_regs_o_slice1", regs_o[0][1*DW +: DW], 32'hDEADBEEF);
        do_op(0, 1'b0, 8'h04, '0, '0, rd);
        expect_word("zero_wait_read", rd, 32'hDEADBEEF);
    endtask

    task automatic test_strobes();
        logic [DW-1:0] rd;
        do_op(0, 1'b1, 8'h08, 32'h11223344, 4'hF, rd);
        do_op(0, 1'b1, 8'h08, 32'hAABBCCDD, 4'b0101, rd);
        do_op(0, 1'b0, 8'h08, '0, '0, rd);
        expect_word("strobe_read", rd, 32'h11BB33DD);
        do_op(0, 1'b1, 8'h08, 32'hFFFFFFFF, 4'b0000, rd);
        do_op(0, 1'b0, 8'h08, '0, '0, rd);
        expect_word("strobe_zero_noop", rd, 32'h11BB33DD);
        bus_idle(0);
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] rd;
        do_op(1, 1'b0, 8'h18, '0, '0, rd);
        do_op(1, 1'b1, 8'h18, 32'h600DCAFE, 4'hF, rd);
        do_op(1, 1'b0, 8'h18, '0, '0, rd);
        expect_word("back_to_back_read", rd, 32'h600DCAFE);
        bus_idle(1);
    endtask

    task automatic test_errors();
        logic [DW-1:0] rd;
        status_i[0][3*DW +: DW] = 32'hCAFE0001;
        do_op(0, 1'b0, 8'h40, '0, '0, rd);
        do_op(0, 1'b1, 8'h05, 32'h55555555, 4'hF, rd);
        do_op(0, 1'b1, 8'h0C, 32'h77777777, 4'hF, rd);
        do_op(0, 1'b0, 8'h0C, '0, '0, rd);
        expect_word("ro_status_read", rd, 32'hCAFE0001);
        do_op(1, 1'b0, 8'h40, '0, '0, rd);
        do_op(1, 1'b1, 8'h1C, 32'h12121212, 4'hF, rd);
        bus_idle(1);
    endtask

    task automatic test_abort();
        logic [DW-1:0] rd;
        @(negedge clk);
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        psel[1]    = 1'b1;
        penable[1] = 1'b0;
        pwrite[1]  = 1'b1;
        paddr[1]   = 8'h18;
        pwdata[1]  = 32'h0BADF00D;
        pstrb[1]   = 4'hF;
        @(negedge clk);
        penable[1] = 1'b1;
        @(negedge clk);
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        expect_word("abort_no_commit", regs_o[1][6*DW +: DW], 32'h600DCAFE);
        do_op(1, 1'b0, 8'h18, '0, '0, rd);
        expect_word("abort_read", rd, 32'h600DCAFE);
        bus_idle(1);
    endtask

    task automatic test_protocol_violation();
        logic [DW-1:0] rd;
        @(negedge clk);
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        psel[0]    = 1'b1;
        penable[0] = 1'b1;
        pwrite[0]  = 1'b1;
        paddr[0]   = 8'h14;
        pwdata[0]  = 32'hA5A5A5A5;
        pstrb[0]   = 4'hF;
        repeat (3) begin
            #1;
            total++;
            if (pready[0] !== 1'b0) begin
                bad++;
                $display("FAIL violation_pready: got %b, required 0", pready[0]);
            end
            @(negedge clk);
        end
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (regs_o[0] !== exp_regs(0)) begin
            bad++;
            $display("FAIL violation_no_write: got %h, required %h", regs_o[0], exp_regs(0));
        end
        do_op(0, 1'b1, 8'h14, 32'h5A5A5A5A, 4'hF, rd);
        do_op(0, 1'b0, 8'h14, '0, '0, rd);
        expect_word("after_violation_read", rd, 32'h5A5A5A5A);
        bus_idle(0);
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] rd;
        @(negedge clk);
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        psel[0]    = 1'b1;
        penable[0] = 1'b0;
        pwrite[0]  = 1'b1;
        paddr[0]   = 8'h10;
        pwdata[0]  = 32'h12345678;
        pstrb[0]   = 4'hF;
        @(negedge clk);
        penable[0] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (pready[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_pready: got %b, required 0", pready[0]);
        end
        @(negedge clk);
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        pwrite[0]  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        expect_word("reset_reg4", regs_o[0][4*DW +: DW], 32'h0);
        total++;
        if (regs_o[0] !== '0 || regs_o[1] !== '0) begin
            bad++;
            $display("FAIL reset_regs_o: got %h / %h, required 0", regs_o[0], regs_o[1]);
        end
        do_op(0, 1'b0, 8'h10, '0, '0, rd);
        expect_word("reset_read", rd, 32'h0);
        bus_idle(0);
    endtask

    task automatic test_random();
        int            d, kind;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        logic [SW-1:0] sb;
        for (int n = 0; n < 300; n++) begin
            d    = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            if (kind < 7)      a = AW'($urandom_range(0, NR - 1) * SW);
            else if (kind < 8) a = AW'($urandom_range(0, 255));
            else               a = AW'($urandom_range(NR, 63) * SW);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            sb = SW'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < NR; i++) status_i[d][i*DW +: DW] = $urandom;
            end
            do_op(d, wr, a, wd, sb, rd);
            if ($urandom_range(0, 3) == 0) bus_idle(d);
        end
        bus_idle(0);
        bus_idle(1);
    endtask

    initial begin
        model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NR; i++)
                status_i[d][i*DW +: DW] = $urandom;
        test_reset();
        test_zero_wait();
        test_strobes();
        test_wait_states();
        test_errors();
        test_abort();
        test_protocol_violation();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
